// File: rtl/ip_rx_serializer_pkg.sv
// Shared definitions for the IP receive serializer: FSM state encoding,
// protocol constants and the prefix byte selector.
package ip_rx_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFIX  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PAD     = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    localparam logic [7:0]  IP_PROTO_UDP = 8'd17;
    localparam logic [2:0]  PREFIX_LEN   = 3'd6;
    localparam logic [31:0] IP_BCAST     = 32'hFFFF_FFFF;

    // Prefix layout: four source IP octets (first octet first), then the
    // payload length high byte and low byte.
    function automatic logic [7:0] prefixByte(input logic [31:0] srcIp,
                                              input logic [15:0] plen,
                                              input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = srcIp[31:24];
            3'd1:    b = srcIp[23:16];
            3'd2:    b = srcIp[15:8];
            3'd3:    b = srcIp[7:0];
            3'd4:    b = plen[15:8];
            default: b = plen[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ip_rx_serializer.sv
// IP receive serializer: filters incoming IP datagrams (UDP to this station)
// and writes a 6-byte prefix (source IP, payload length) followed by exactly
// payload-length bytes into a downstream FIFO. Short payloads are zero padded,
// long ones truncated, rejected datagrams drained and counted.
// Optional build macro: IP_RX_SER_BCAST_EN also accepts 255.255.255.255.
module ip_rx_serializer
    import ip_rx_serializer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] local_ip,
    input  logic        rx_hdr_valid,
    output logic        rx_hdr_ready,
    input  logic [3:0]  rx_ip_ihl,
    input  logic [15:0] rx_ip_length,
    input  logic [7:0]  rx_ip_protocol,
    input  logic [31:0] rx_ip_source_ip,
    input  logic [31:0] rx_ip_dest_ip,
    input  logic [7:0]  rx_payload_tdata,
    input  logic        rx_payload_tvalid,
    output logic        rx_payload_tready,
    input  logic        rx_payload_tlast,
    output logic [7:0]  dout_din,
    input  logic        dout_full_n,
    output logic        dout_write,
    output logic [15:0] drop_count
);

    state_t      r_state;
    logic [31:0] r_srcIp;
    logic [15:0] r_plen;
    logic [2:0]  r_idx;
    logic [15:0] r_cnt;
    logic [15:0] r_dropCount;

    state_t      w_nextState;
    logic [2:0]  w_idxNext;
    logic [15:0] w_cntNext;
    logic [15:0] w_cntInc;
    logic [15:0] w_hdrBytes;
    logic [15:0] w_hdrPlen;
    logic        w_destOk;
    logic        w_accept;
    logic        w_latch;
    logic        w_drop;
    logic        w_hdrReady;

    assign w_hdrBytes = {10'd0, rx_ip_ihl, 2'b00};
    assign w_hdrPlen  = rx_ip_length - w_hdrBytes;
    assign w_cntInc   = r_cnt + 16'd1;

`ifdef IP_RX_SER_BCAST_EN
    assign w_destOk = (rx_ip_dest_ip == local_ip) || (rx_ip_dest_ip == IP_BCAST);
`else
    assign w_destOk = (rx_ip_dest_ip == local_ip);
`endif

    assign w_accept = (rx_ip_protocol == IP_PROTO_UDP) && (rx_ip_ihl >= 4'd5) &&
                      (rx_ip_length > w_hdrBytes) && w_destOk;

    // Header ready is forced low while reset is held so nothing is accepted.
    assign rx_hdr_ready = w_hdrReady && reset_n;
    assign drop_count   = r_dropCount;

    // Next-state, handshake and FIFO write decode for the current state.
    always_comb begin
        w_nextState       = r_state;
        w_idxNext         = r_idx;
        w_cntNext         = r_cnt;
        w_latch           = 1'b0;
        w_drop            = 1'b0;
        w_hdrReady        = 1'b0;
        rx_payload_tready = 1'b0;
        dout_write        = 1'b0;
        dout_din          = 8'h00;
        case (r_state)
            ST_IDLE: begin
                w_hdrReady = 1'b1;
                if (rx_hdr_valid) begin
                    w_latch   = 1'b1;
                    w_idxNext = 3'd0;
                    w_cntNext = 16'd0;
                    if (w_accept) begin
                        w_nextState = ST_PREFIX;
                    end else begin
                        w_drop      = 1'b1;
                        w_nextState = ST_DRAIN;
                    end
                end
            end
            ST_PREFIX: begin
                dout_din   = prefixByte(r_srcIp, r_plen, r_idx);
                dout_write = dout_full_n;
                if (dout_full_n) begin
                    if (r_idx == PREFIX_LEN - 3'd1) begin
                        w_idxNext   = 3'd0;
                        w_nextState = ST_PAYLOAD;
                    end else begin
                        w_idxNext = r_idx + 3'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                rx_payload_tready = dout_full_n;
                dout_din          = rx_payload_tdata;
                if (rx_payload_tvalid && dout_full_n) begin
                    dout_write = 1'b1;
                    w_cntNext  = w_cntInc;
                    if (w_cntInc == r_plen) begin
                        w_nextState = rx_payload_tlast ? ST_IDLE : ST_DRAIN;
                    end else if (rx_payload_tlast) begin
                        w_nextState = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                dout_write = dout_full_n;
                if (dout_full_n) begin
                    w_cntNext = w_cntInc;
                    if (w_cntInc == r_plen) begin
                        w_nextState = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                rx_payload_tready = 1'b1;
                if (rx_payload_tvalid && rx_payload_tlast) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State, latched header fields, counters and the saturating drop counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_srcIp     <= 32'd0;
            r_plen      <= 16'd0;
            r_idx       <= 3'd0;
            r_cnt       <= 16'd0;
            r_dropCount <= 16'd0;
        end else begin
            r_state <= w_nextState;
            r_idx   <= w_idxNext;
            r_cnt   <= w_cntNext;
            if (w_latch) begin
                r_srcIp <= rx_ip_source_ip;
                r_plen  <= w_hdrPlen;
            end
            if (w_drop && (r_dropCount != 16'hFFFF)) begin
                r_dropCount <= r_dropCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ip_rx_serializer.sv
// Self-checking bench for ip_rx_serializer. A datagram-level model predicts
// the byte stream and drop count; a compare process checks every FIFO write.
module tb_ip_rx_serializer;

    localparam logic [31:0] LOCAL_IP = 32'hC0A8_0164;
    localparam logic [31:0] SRC_IP   = 32'hC0A8_0102;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_hdr_valid = 1'b0;
    logic        rx_hdr_ready;
    logic [3:0]  rx_ip_ihl = 4'd0;
    logic [15:0] rx_ip_length = 16'd0;
    logic [7:0]  rx_ip_protocol = 8'd0;
    logic [31:0] rx_ip_source_ip = 32'd0;
    logic [31:0] rx_ip_dest_ip = 32'd0;
    logic [7:0]  rx_payload_tdata = 8'd0;
    logic        rx_payload_tvalid = 1'b0;
    logic        rx_payload_tready;
    logic        rx_payload_tlast = 1'b0;
    logic [7:0]  dout_din;
    logic        dout_full_n = 1'b1;
    logic        dout_write;
    logic [15:0] drop_count;

    int          nAssert = 0;
    int          nFail = 0;
    logic [7:0]  expQ[$];
    logic [7:0]  writeLog[$];
    logic [7:0]  beatQ[$];
    int          expDrop = 0;
    bit          toggleEn = 1'b0;

    ip_rx_serializer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .local_ip          (LOCAL_IP),
        .rx_hdr_valid      (rx_hdr_valid),
        .rx_hdr_ready      (rx_hdr_ready),
        .rx_ip_ihl         (rx_ip_ihl),
        .rx_ip_length      (rx_ip_length),
        .rx_ip_protocol    (rx_ip_protocol),
        .rx_ip_source_ip   (rx_ip_source_ip),
        .rx_ip_dest_ip     (rx_ip_dest_ip),
        .rx_payload_tdata  (rx_payload_tdata),
        .rx_payload_tvalid (rx_payload_tvalid),
        .rx_payload_tready (rx_payload_tready),
        .rx_payload_tlast  (rx_payload_tlast),
        .dout_din          (dout_din),
        .dout_full_n       (dout_full_n),
        .dout_write        (dout_write),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(input string name, input logic [31:0] act,
                                        input logic [31:0] req);
        nAssert++;
        if (act !== req) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // FIFO backpressure: held ready, or toggled every cycle when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dout_full_n = toggleEn ? ~dout_full_n : 1'b1;
        end
    end

    // Every write is checked against the model's next byte and logged.
    always @(negedge clk) begin
        if (reset_n) begin
            checkOutput("writeGatedByFull", {31'd0, dout_write & ~dout_full_n}, 32'd0);
            if (dout_write) begin
                writeLog.push_back(dout_din);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedWrite", {24'd0, dout_din}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("doutByte", {24'd0, dout_din}, {24'd0, expQ.pop_front()});
                end
            end
        end
    end

    // Datagram-level model: accept rule, prefix, then exactly plen bytes.
    task automatic modelDatagram(input logic [7:0] proto, input logic [3:0] ihl,
                                 input logic [15:0] len, input logic [31:0] dest,
                                 input int nBeats);
        int plen;
        bit destOk;
        bit accept;
        plen = int'(len) - 4 * int'(ihl);
        destOk = (dest == LOCAL_IP);
`ifdef IP_RX_SER_BCAST_EN
        if (dest == 32'hFFFF_FFFF) destOk = 1'b1;
`endif
        accept = (proto == 8'd17) && (ihl >= 4'd5) && (plen > 0) && destOk;
        if (accept) begin
            expQ.push_back(SRC_IP[31:24]);
            expQ.push_back(SRC_IP[23:16]);
            expQ.push_back(SRC_IP[15:8]);
            expQ.push_back(SRC_IP[7:0]);
            expQ.push_back(plen[15:8]);
            expQ.push_back(plen[7:0]);
            for (int k = 0; k < plen; k++) begin
                expQ.push_back((k < nBeats) ? beatQ[k] : 8'h00);
            end
        end else if (expDrop < 65535) begin
            expDrop++;
        end
    endtask

    task automatic sendHeader(input logic [7:0] proto, input logic [3:0] ihl,
                              input logic [15:0] len, input logic [31:0] dest);
        bit hs = 1'b0;
        rx_hdr_valid    = 1'b1;
        rx_ip_protocol  = proto;
        rx_ip_ihl       = ihl;
        rx_ip_length    = len;
        rx_ip_source_ip = SRC_IP;
        rx_ip_dest_ip   = dest;
        for (int k = 0; k < 50 && !hs; k++) begin
            @(negedge clk);
            hs = rx_hdr_ready;
            @(posedge clk);
            #1;
        end
        rx_hdr_valid = 1'b0;
        checkOutput("hdrHandshake", {31'd0, hs}, 32'd1);
    endtask

    task automatic sendBeats(input int n, input bit lastOnFinal);
        bit hs;
        bit allOk = 1'b1;
        for (int i = 0; i < n; i++) begin
            rx_payload_tvalid = 1'b1;
            rx_payload_tdata  = beatQ[i];
            rx_payload_tlast  = lastOnFinal && (i == n - 1);
            hs = 1'b0;
            for (int k = 0; k < 60 && !hs; k++) begin
                @(negedge clk);
                hs = rx_payload_tready;
                @(posedge clk);
                #1;
            end
            if (!hs) allOk = 1'b0;
        end
        rx_payload_tvalid = 1'b0;
        rx_payload_tlast  = 1'b0;
        checkOutput("beatsConsumed", {31'd0, allOk}, 32'd1);
    endtask

    task automatic waitIdle();
        bit seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            seen = rx_hdr_ready;
        end
        @(posedge clk);
        #1;
        checkOutput("idleReached", {31'd0, seen}, 32'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] proto, input logic [3:0] ihl,
                                 input logic [15:0] len, input logic [31:0] dest,
                                 input int nBeats, input logic [7:0] first);
        beatQ.delete();
        for (int i = 0; i < nBeats; i++) beatQ.push_back(first + 8'(i));
        writeLog.delete();
        modelDatagram(proto, ihl, len, dest, nBeats);
        sendHeader(proto, ihl, len, dest);
        sendBeats(nBeats, 1'b1);
        waitIdle();
        checkOutput("allBytesWritten", expQ.size(), 32'd0);
        checkOutput("dropCount", {16'd0, drop_count}, expDrop);
    endtask

    task automatic checkLiteral28();
        logic [7:0] lit[14] = '{8'hC0, 8'hA8, 8'h01, 8'h02, 8'h00, 8'h08,
                                8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        checkOutput("lit28Count", writeLog.size(), 32'd14);
        for (int i = 0; i < 14; i++) begin
            checkOutput("lit28Byte", {24'd0, writeLog[i]}, {24'd0, lit[i]});
        end
    endtask

    initial begin
        // Reset state.
        #2;
        checkOutput("rstHdrReady", {31'd0, rx_hdr_ready}, 32'd0);
        checkOutput("rstWrite", {31'd0, dout_write}, 32'd0);
        checkOutput("rstTready", {31'd0, rx_payload_tready}, 32'd0);
        checkOutput("rstDrop", {16'd0, drop_count}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("hdrReadyAfterRelease", {31'd0, rx_hdr_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Nominal 8-byte UDP datagram.
        applyStimulus(8'd17, 4'd5, 16'd28, LOCAL_IP, 8, 8'h01);
        checkLiteral28();

        // Same datagram under alternating backpressure.
        toggleEn = 1'b1;
        applyStimulus(8'd17, 4'd5, 16'd28, LOCAL_IP, 8, 8'h01);
        checkLiteral28();
        toggleEn = 1'b0;

        // Short payload padded to the advertised length.
        applyStimulus(8'd17, 4'd5, 16'd30, LOCAL_IP, 6, 8'h01);
        checkOutput("padCount", writeLog.size(), 32'd16);
        checkOutput("padLenHi", {24'd0, writeLog[4]}, 32'h00);
        checkOutput("padLenLo", {24'd0, writeLog[5]}, 32'h0A);
        checkOutput("padLastData", {24'd0, writeLog[11]}, 32'h06);
        for (int i = 12; i < 16; i++) checkOutput("padZero", {24'd0, writeLog[i]}, 32'h00);

        // TCP dropped, all beats still consumed.
        applyStimulus(8'd6, 4'd5, 16'd28, LOCAL_IP, 5, 8'h40);
        checkOutput("tcpNoWrites", writeLog.size(), 32'd0);
        checkOutput("tcpDrop", {16'd0, drop_count}, 32'd1);

        // Excess beats truncated without counting a drop.
        applyStimulus(8'd17, 4'd5, 16'd24, LOCAL_IP, 6, 8'h11);
        checkOutput("excessCount", writeLog.size(), 32'd10);

        // Smallest payload: one byte.
        applyStimulus(8'd17, 4'd5, 16'd21, LOCAL_IP, 1, 8'h5A);

        // Rejections: ihl below 5, length equal to header, foreign destination.
        applyStimulus(8'd17, 4'd4, 16'd28, LOCAL_IP, 2, 8'h60);
        applyStimulus(8'd17, 4'd5, 16'd20, LOCAL_IP, 1, 8'h70);
        applyStimulus(8'd17, 4'd5, 16'd28, 32'h0A00_0001, 3, 8'h80);

        // Broadcast destination, build dependent.
        applyStimulus(8'd17, 4'd5, 16'd28, 32'hFFFF_FFFF, 8, 8'h90);

        // Reset in the middle of a payload.
        beatQ.delete();
        for (int i = 0; i < 8; i++) beatQ.push_back(8'h21 + 8'(i));
        writeLog.delete();
        modelDatagram(8'd17, 4'd5, 16'd28, LOCAL_IP, 8);
        sendHeader(8'd17, 4'd5, 16'd28, LOCAL_IP);
        sendBeats(3, 1'b0);
        checkOutput("writesBeforeReset", writeLog.size(), 32'd9);
        reset_n = 1'b0;
        #1;
        checkOutput("midRstWrite", {31'd0, dout_write}, 32'd0);
        checkOutput("midRstTready", {31'd0, rx_payload_tready}, 32'd0);
        checkOutput("midRstHdrReady", {31'd0, rx_hdr_ready}, 32'd0);
        checkOutput("midRstDrop", {16'd0, drop_count}, 32'd0);
        expQ.delete();
        expDrop = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("postRstHdrReady", {31'd0, rx_hdr_ready}, 32'd1);
        checkOutput("postRstNoWrite", {31'd0, dout_write}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(8'd17, 4'd5, 16'd28, LOCAL_IP, 8, 8'h01);
        checkLiteral28();

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
